// File: rtl/fp_pkg.sv
// Shared FP result types and helpers for the rounding stage.
// Holds the operand/result layouts and the round-robin pick used by the arbiter.
package fp_pkg;

  localparam int EXP_W     = 8;
  localparam int FRAC_W    = 23;
  localparam int MANT_IN_W = 26;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef struct packed {
    logic                 sign;
    logic [EXP_W-1:0]     exp;
    logic [MANT_IN_W-1:0] mantis;
    logic                 operator;
    logic                 loss;
  } unround_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
    logic              ovf;
  } rounded_t;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  // First valid requester scanning ptr, ptr+1, ... modulo n (n is 2..4).
  function automatic pick_t rr_pick(input logic [3:0] valid, input int unsigned ptr,
                                    input int unsigned n);
    pick_t       p;
    int unsigned cand;
    p = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      cand = (ptr + k) % n;
      if (!p.found && valid[cand[1:0]]) begin
        p.found = 1'b1;
        p.idx   = cand[1:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/fp_round_arbiter_round.sv
// Combinational round-to-nearest-even unit for one unrounded FP operand.
// A non-zero input exponent keeps the fraction below the hidden bit; zero exponent drops bit 0.
module fp_round_arbiter_round
  import fp_pkg::*;
(
  input  logic                 sign,
  input  logic [EXP_W-1:0]     exp,
  input  logic [MANT_IN_W-1:0] mantis,
  input  logic                 operator,
  input  logic                 loss,
  output logic                 res_sign,
  output logic [EXP_W-1:0]     res_exp,
  output logic [FRAC_W-1:0]    res_frac,
  output logic                 res_ovf
);

  logic [1:0]  round_bits_s;
  logic        sticky_s;
  logic        round_up_s;
  logic [24:0] sum_s;

  // Sticky comes from the alignment loss when present (add path rounds up, sub path does not).
  always_comb begin
    round_bits_s = mantis[1:0];
    sticky_s     = loss ? !operator : mantis[2];
    round_up_s   = (round_bits_s == 2'b11) | ((round_bits_s == 2'b10) & sticky_s);
    sum_s        = {1'b0, mantis[25:2]} + {24'd0, round_up_s};
    res_sign     = sign;
    res_exp      = exp + {7'd0, sum_s[24]};
    res_frac     = (exp != 8'h00) ? sum_s[22:0] : sum_s[23:1];
    res_ovf      = (res_exp == EXP_MAX);
  end

endmodule

// File: rtl/fp_round_arbiter.sv
// Round-robin arbiter sharing one rounding unit between NREQ normalize stages.
// The granted operand is rounded and captured, with its source tag, in a single output register.
module fp_round_arbiter
  import fp_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ-1:0]           req_sign,
  input  logic [EXP_W*NREQ-1:0]     req_exp,
  input  logic [MANT_IN_W*NREQ-1:0] req_mantis,
  input  logic [NREQ-1:0]           req_operator,
  input  logic [NREQ-1:0]           req_loss,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic                      res_sign,
  output logic [EXP_W-1:0]          res_exp,
  output logic [FRAC_W-1:0]         res_mantis,
  output logic                      res_ovf,
  output logic [IDW-1:0]            res_src,
  output logic                      busy
);

  unround_t        op_s [NREQ];
  unround_t        sel_s;
  pick_t           pick_s;
  rounded_t        rnd_s;
  logic [3:0]      valid_pad_s;
  logic [NREQ-1:0] grant_s;
  logic [IDW-1:0]  grant_idx_s;
  logic [IDW-1:0]  next_ptr_s;
  logic            can_accept_s;
  logic            accept_s;

  logic [IDW-1:0]  ptr_r;
  logic            res_valid_r;
  rounded_t        res_r;
  logic [IDW-1:0]  res_src_r;

  // Unpack the flat requester buses into per-requester operands.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      op_s[i].sign     = req_sign[i];
      op_s[i].exp      = req_exp[EXP_W*i +: EXP_W];
      op_s[i].mantis   = req_mantis[MANT_IN_W*i +: MANT_IN_W];
      op_s[i].operator = req_operator[i];
      op_s[i].loss     = req_loss[i];
    end
  end

  // Grant selection and handshake; the register frees up in the same cycle it drains.
  always_comb begin
    valid_pad_s             = 4'b0000;
    valid_pad_s[NREQ-1:0]   = req_valid;
    pick_s                  = rr_pick(valid_pad_s, 32'(ptr_r), NREQ);
    grant_idx_s             = IDW'(pick_s.idx);
    grant_s                 = '0;
    if (pick_s.found) begin
      grant_s[grant_idx_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
    can_accept_s = !res_valid_r | res_ready;
    req_ready    = grant_s & {NREQ{can_accept_s & rst_n}};
    accept_s     = pick_s.found & can_accept_s;
    next_ptr_s   = (grant_idx_s == IDW'(NREQ - 1)) ? '0 : grant_idx_s + IDW'(1);
    sel_s        = op_s[grant_idx_s];
  end

  fp_round_arbiter_round u_round (
    .sign     (sel_s.sign),
    .exp      (sel_s.exp),
    .mantis   (sel_s.mantis),
    .operator (sel_s.operator),
    .loss     (sel_s.loss),
    .res_sign (rnd_s.sign),
    .res_exp  (rnd_s.exp),
    .res_frac (rnd_s.frac),
    .res_ovf  (rnd_s.ovf)
  );

  // Result register and round-robin pointer; data holds when the register drains empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r       <= '0;
      res_valid_r <= 1'b0;
      res_r       <= '0;
      res_src_r   <= '0;
    end else if (accept_s) begin
      ptr_r       <= next_ptr_s;
      res_valid_r <= 1'b1;
      res_r       <= rnd_s;
      res_src_r   <= grant_idx_s;
    end else begin
      res_valid_r <= res_valid_r & !res_ready;
    end
  end

  assign res_valid  = res_valid_r;
  assign res_sign   = res_r.sign;
  assign res_exp    = res_r.exp;
  assign res_mantis = res_r.frac;
  assign res_ovf    = res_r.ovf;
  assign res_src    = res_src_r;
  assign busy       = res_valid_r | (|req_valid);

endmodule

// File: tb/tb_fp_round_arbiter.sv
// Self-checking bench for fp_round_arbiter (NREQ=2): scoreboard of rounded results
// against an arithmetic reference, plus directed checks for arbitration, stalls and reset.
module tb_fp_round_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, req_sign, req_operator, req_loss;
  logic [15:0] req_exp;
  logic [51:0] req_mantis;
  logic        res_valid, res_ready, res_sign, res_ovf, busy;
  logic [7:0]  res_exp;
  logic [22:0] res_mantis;
  logic [0:0]  res_src;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
    logic        ovf;
    logic        src;
  } exp_t;

  exp_t sb_q[$];
  int   m_ptr;
  logic m_valid;

  fp_round_arbiter #(.NREQ(2), .IDW(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_sign(req_sign), .req_exp(req_exp), .req_mantis(req_mantis),
    .req_operator(req_operator), .req_loss(req_loss), .res_valid(res_valid),
    .res_ready(res_ready), .res_sign(res_sign), .res_exp(res_exp),
    .res_mantis(res_mantis), .res_ovf(res_ovf), .res_src(res_src), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference rounding in plain integer arithmetic.
  function automatic exp_t model(input int src, input logic sg, input logic [7:0] e,
                                 input logic [25:0] m, input logic op, input logic ls);
    int   keep, rb, up, total, ee;
    logic st;
    exp_t r;
    keep  = int'(m) / 4;
    rb    = int'(m) % 4;
    st    = ls ? ~op : m[2];
    up    = (rb == 3 || (rb == 2 && st)) ? 1 : 0;
    total = keep + up;
    ee    = int'(e) + total / 16777216;
    total = total % 16777216;
    r.sign = sg;
    r.exp  = 8'(ee % 256);
    r.frac = (e != 8'd0) ? 23'(total % 8388608) : 23'(total / 2);
    r.ovf  = (r.exp == 8'hFF);
    r.src  = 1'(src);
    return r;
  endfunction

  // Scoreboard monitor: models arbitration, pushes on accept, pops on drain.
  initial begin
    int      g, idx;
    logic    can_acc;
    logic [1:0] exp_ready;
    exp_t    e;
    m_ptr   = 0;
    m_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        checks++;
        if (req_ready !== 2'b00 || res_valid !== 1'b0) begin
          errors++;
          $display("FAIL reset_hold: ready=%b valid=%b, want 00/0", req_ready, res_valid);
        end
        sb_q.delete();
        m_ptr   = 0;
        m_valid = 1'b0;
      end else begin
        checks++;
        if (res_valid !== m_valid) begin
          errors++;
          $display("FAIL sb_res_valid: got %b want %b", res_valid, m_valid);
        end
        g = -1;
        for (int k = 0; k < 2; k++) begin
          idx = (m_ptr + k) % 2;
          if (g < 0 && req_valid[idx]) g = idx;
        end
        can_acc   = !m_valid || res_ready;
        exp_ready = 2'b00;
        if (g >= 0 && can_acc) exp_ready[g] = 1'b1;
        checks++;
        if (req_ready !== exp_ready) begin
          errors++;
          $display("FAIL sb_req_ready: got %b want %b", req_ready, exp_ready);
        end
        if (m_valid && res_ready) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_underflow: result drained with empty scoreboard");
          end else begin
            e = sb_q.pop_front();
            if ({res_sign, res_exp, res_mantis, res_ovf, res_src} !== e) begin
              errors++;
              $display("FAIL sb_result: got s=%b e=%h f=%h o=%b src=%0d want s=%b e=%h f=%h o=%b src=%0d",
                       res_sign, res_exp, res_mantis, res_ovf, res_src,
                       e.sign, e.exp, e.frac, e.ovf, e.src);
            end
          end
        end
        if (g >= 0 && can_acc) begin
          sb_q.push_back(model(g, req_sign[g], req_exp[8*g +: 8], req_mantis[26*g +: 26],
                               req_operator[g], req_loss[g]));
          m_ptr   = (g + 1) % 2;
          m_valid = 1'b1;
        end else if (res_ready) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  task automatic set_req(input int i, input logic sg, input logic [7:0] e,
                         input logic [25:0] m, input logic op, input logic ls);
    req_sign[i]             = sg;
    req_exp[8*i +: 8]       = e;
    req_mantis[26*i +: 26]  = m;
    req_operator[i]         = op;
    req_loss[i]             = ls;
  endtask

  // Presents one operand and returns at #1 after the edge that accepted it.
  task automatic send(input int i, input logic sg, input logic [7:0] e,
                      input logic [25:0] m, input logic op, input logic ls);
    logic ok;
    set_req(i, sg, e, m, op, ls);
    req_valid[i] = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      ok = req_ready[i];
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: req %0d ready stayed 0, want 1", i);
    end
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", res_valid); end
    checks++; if (res_exp !== 8'h00) begin errors++; $display("FAIL rst_exp: got %h want 00", res_exp); end
    checks++; if (res_mantis !== 23'h0) begin errors++; $display("FAIL rst_mantis: got %h want 0", res_mantis); end
    checks++; if ({res_sign, res_ovf, res_src} !== 3'b000) begin errors++; $display("FAIL rst_misc: got %b want 000", {res_sign, res_ovf, res_src}); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b want 00", req_ready); end
    req_valid = 2'b00;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_round_even;
    send(0, 1'b0, 8'h80, 26'h0000006, 1'b0, 1'b0);
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL rne_valid: got %b want 1", res_valid); end
    checks++; if (res_exp !== 8'h80) begin errors++; $display("FAIL rne_exp: got %h want 80", res_exp); end
    checks++; if (res_mantis !== 23'h000002) begin errors++; $display("FAIL rne_mantis: got %h want 000002", res_mantis); end
    checks++; if (res_src !== 1'b0) begin errors++; $display("FAIL rne_src: got %0d want 0", res_src); end
  endtask

  task automatic test_sticky;
    send(1, 1'b1, 8'h80, 26'h0000006, 1'b1, 1'b1);
    checks++; if ({res_sign, res_mantis} !== {1'b1, 23'h000001}) begin errors++; $display("FAIL sticky_sub: got %b/%h want 1/000001", res_sign, res_mantis); end
    send(0, 1'b0, 8'h80, 26'h0000002, 1'b0, 1'b1);
    checks++; if (res_mantis !== 23'h000001) begin errors++; $display("FAIL sticky_add: got %h want 000001", res_mantis); end
  endtask

  task automatic test_carry;
    send(1, 1'b0, 8'h7F, 26'h3FFFFFF, 1'b0, 1'b0);
    checks++; if ({res_exp, res_mantis, res_ovf} !== {8'h80, 23'h0, 1'b0}) begin errors++; $display("FAIL carry_exp: got %h/%h/%b want 80/0/0", res_exp, res_mantis, res_ovf); end
    checks++; if (res_src !== 1'b1) begin errors++; $display("FAIL carry_src: got %0d want 1", res_src); end
    send(1, 1'b0, 8'hFE, 26'h3FFFFFF, 1'b0, 1'b0);
    checks++; if ({res_exp, res_ovf} !== {8'hFF, 1'b1}) begin errors++; $display("FAIL carry_ovf: got %h/%b want FF/1", res_exp, res_ovf); end
  endtask

  task automatic test_denormal;
    send(1, 1'b0, 8'h00, 26'h0000004, 1'b0, 1'b0);
    checks++; if ({res_exp, res_mantis} !== {8'h00, 23'h0}) begin errors++; $display("FAIL denorm: got %h/%h want 00/000000", res_exp, res_mantis); end
  endtask

  task automatic test_fairness;
    logic [1:0] want;
    set_req(0, 1'b0, 8'h40, 26'h0000010, 1'b0, 1'b0);
    set_req(1, 1'b1, 8'h41, 26'h0000013, 1'b0, 1'b0);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      want = (k % 2 == 0) ? 2'b01 : 2'b10;
      checks++; if (req_ready !== want) begin errors++; $display("FAIL fair_ready%0d: got %b want %b", k, req_ready, want); end
      @(posedge clk);
      #1;
      checks++; if (res_src !== 1'(k % 2)) begin errors++; $display("FAIL fair_src%0d: got %0d want %0d", k, res_src, k % 2); end
    end
    req_valid = 2'b00;
  endtask

  task automatic test_backpressure;
    repeat (2) @(posedge clk);
    #1;
    set_req(0, 1'b0, 8'h10, 26'h000000C, 1'b0, 1'b0);
    req_valid = 2'b01;
    res_ready = 1'b0;
    @(posedge clk);
    #1;
    set_req(0, 1'b0, 8'h20, 26'h0000007, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL stall_ready%0d: got %b want 00", k, req_ready); end
      checks++; if ({res_valid, res_exp, res_mantis} !== {1'b1, 8'h10, 23'h000003}) begin errors++; $display("FAIL stall_hold%0d: got %b/%h/%h want 1/10/000003", k, res_valid, res_exp, res_mantis); end
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL release_ready: got %b want 01", req_ready); end
    @(posedge clk);
    #1;
    checks++; if ({res_valid, res_exp, res_mantis} !== {1'b1, 8'h20, 23'h000002}) begin errors++; $display("FAIL no_bubble: got %b/%h/%h want 1/20/000002", res_valid, res_exp, res_mantis); end
  endtask

  task automatic test_reset_mid_stall;
    res_ready = 1'b0;
    set_req(1, 1'b0, 8'h33, 26'h0000008, 1'b0, 1'b0);
    req_valid = 2'b10;
    @(posedge clk);
    #1;
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b want 1", res_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid: got %b want 0", res_valid); end
    set_req(0, 1'b1, 8'h55, 26'h0000001, 1'b0, 1'b0);
    req_valid = 2'b11;
    res_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    checks++; if ({res_valid, res_src} !== 2'b10) begin errors++; $display("FAIL post_reset_grant: got valid=%b src=%0d want 1/0", res_valid, res_src); end
  endtask

  task automatic test_drain;
    req_valid = 2'b00;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL drain_sb: %0d results left, want 0", sb_q.size()); end
    checks++; if ({res_valid, busy} !== 2'b00) begin errors++; $display("FAIL drain_idle: got %b want 00", {res_valid, busy}); end
  endtask

  initial begin
    rst_n        = 1'b0;
    req_valid    = 2'b11;
    req_sign     = 2'b00;
    req_operator = 2'b00;
    req_loss     = 2'b00;
    req_exp      = 16'h0000;
    req_mantis   = 52'h0;
    res_ready    = 1'b1;
    test_reset;
    test_round_even;
    test_sticky;
    test_carry;
    test_denormal;
    test_fairness;
    test_backpressure;
    test_reset_mid_stall;
    test_drain;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
